secventiator_faze: RTL and testbench
====================================

SECVENTIATOR_FAZE -- requirements
Module: secventiator_faze

Interface
REQ-001 SHALL take parameter T_VERDE, default 30: green duration in tick_i pulses.
REQ-002 SHALL take parameter T_GALBEN, default 3: yellow duration in tick_i pulses.
REQ-003 SHALL take parameter T_ROSU_TOTAL, default 2: all-red clearance duration in tick_i pulses.
REQ-004 SHALL take parameter T_MIN_VERDE, default 10: minimum green before a pedestrian cut, in tick_i pulses.
REQ-005 SHALL take parameter LATIME_CNT, default 8: phase counter width.
REQ-006 SHALL have clk_i, input, 1: the single clock.
REQ-007 SHALL have rst_i, input, 1: the reset; one clock, reset is synchronous and active-high.
REQ-008 SHALL have enable_i, input, 1: when 1, the sequencer advances; when 0, it freezes.
REQ-009 SHALL have tick_i, input, 1: one-cycle timebase pulse.
REQ-010 SHALL have urgenta_i, input, 1: emergency request; level-sensitive.
REQ-011 SHALL have cerere_pieton_i, input, 1: pedestrian request; single-cycle pulse.
REQ-012 SHALL have w_ns_o, output, 2: light code for north-south (00 red, 01 yellow, 10 green, 11 all-red).
REQ-013 SHALL have tranzit_ns_o, output, 1: north-south yellow transit flag.
REQ-014 SHALL have w_ev_o, output, 2: light code for east-west, same encoding as w_ns_o.
REQ-015 SHALL have tranzit_ev_o, output, 1: east-west yellow transit flag.
REQ-016 SHALL have faza_o, output, 3: current state encoding, for debug.

Function
REQ-017 SHALL implement the FSM states ROSU_INIT, NS_VERDE, NS_GALBEN, ROSU_1, EV_VERDE, EV_GALBEN, ROSU_2 and URGENTA.
REQ-018 SHALL follow the cycle ROSU_INIT->NS_VERDE->NS_GALBEN->ROSU_1->EV_VERDE->EV_GALBEN->ROSU_2->NS_VERDE.
REQ-019 SHALL time each state with a phase counter that increments only on cycles with enable_i=1 and tick_i=1, and SHALL leave the state on the tick where counter==duration-1 (state durations: ROSU_* T_ROSU_TOTAL; *_VERDE T_VERDE; *_GALBEN T_GALBEN).
REQ-020 SHALL clear the counter to 0 on every state change.
REQ-021 SHALL register all outputs and update them on the same clock edge as the state register, with no combinational path from input to output.
REQ-022 SHALL drive outputs per state as follows:
- NS_VERDE: w_ns 10, w_ev 00.
- NS_GALBEN: w_ns 01, tranzit_ns 1, w_ev 00.
- EV_VERDE and EV_GALBEN: mirror of the NS states.
- ROSU_*: both w=11.
- URGENTA: both w=11.
- All other cases: tranzit=0.
REQ-023 SHALL guarantee that w_ns_o and w_ev_o are never both non-red (10/01) in the same cycle.
REQ-024 SHALL freeze state, counter and outputs while enable_i=0, and SHALL ignore tick_i in that condition.
REQ-025 SHALL enter URGENTA on the next edge from any state when urgenta_i=1, regardless of enable_i or tick_i, and SHALL hold URGENTA while urgenta_i=1.
REQ-026 SHALL go from URGENTA to ROSU_INIT with the counter at 0 on the first cycle urgenta_i=0.
REQ-027 SHALL give urgenta_i priority over every timer expiry and pedestrian event occurring in the same cycle.
REQ-028 SHALL saturate the counter at its maximum and never wrap; parameters SHALL each be at least 1 and at most 2^LATIME_CNT.

Reset
REQ-029 SHALL, on rst_i=1 at a clock edge, set: state ROSU_INIT, counter 0, w_ns_o=w_ev_o=11, tranzit_*=0, pedestrian latch 0, faza_o=ROSU_INIT.
REQ-030 SHALL give reset priority over urgenta_i and enable_i, and SHALL abort any phase in progress when asserted mid-sequence.

Configuration
REQ-031 SHALL, with PIETON_EN defined, latch cerere_pieton_i into a sticky flag, and SHALL, while in a *_VERDE state with counter>=T_MIN_VERDE-1 and the flag set, move to the matching *_GALBEN on the next enabled tick.
REQ-032 SHALL clear the pedestrian flag on entry to ROSU_1 or ROSU_2.
REQ-033 SHALL, without PIETON_EN, keep the cerere_pieton_i port and ignore it, with no flag flop present.

Structure
REQ-034 SHALL place the light-code constants (ROSU, GALBEN, VERDE, ROSU_TOTAL) and the state encoding in the shared package faze_pkg, reused by the per-direction light controllers.
REQ-035 SHALL place the phase counter with its saturation and terminal-count compare in the sub-module contor_faza.

Verification
REQ-036 SHALL verify reset: hold rst_i for 2 cycles, then tick every cycle -> w=11/11 for 2 ticks, then w_ns=10.
REQ-037 SHALL verify the full cycle with default parameters: NS green for exactly 30 ticks, yellow for 3 with tranzit_ns=1, all-red for 2, then EV green, and w_ns/w_ev are never simultaneously non-red.
REQ-038 SHALL verify freeze: drop enable_i for 50 cycles at NS_VERDE count 5 while tick_i keeps pulsing -> state and count are unchanged, and the sequence resumes at count 5.
REQ-039 SHALL verify emergency: pulse urgenta_i for 4 cycles during EV_VERDE -> next edge w=11/11, then ROSU_INIT for 2 ticks, then NS_VERDE.
REQ-040 SHALL verify the pedestrian cut (PIETON_EN): pulse cerere_pieton_i at NS_VERDE count 3 -> NS_GALBEN entered at count 9 (10th tick); an identical pulse with the macro undefined -> a full 30-tick green.
REQ-041 SHALL verify simultaneous events: terminal tick, urgenta_i and rst_i in the same cycle -> ROSU_INIT; without rst_i -> URGENTA.

Source files
------------

// File: rtl/faze_pkg.sv
// Shared light codes, sequencer state encoding and per-direction light decode
// used by the two-direction phase sequencer.
package faze_pkg;

  localparam logic [1:0] ROSU       = 2'b00;
  localparam logic [1:0] GALBEN     = 2'b01;
  localparam logic [1:0] VERDE      = 2'b10;
  localparam logic [1:0] ROSU_TOTAL = 2'b11;

  typedef enum logic [2:0] {
    ROSU_INIT = 3'd0,
    NS_VERDE  = 3'd1,
    NS_GALBEN = 3'd2,
    ROSU_1    = 3'd3,
    EV_VERDE  = 3'd4,
    EV_GALBEN = 3'd5,
    ROSU_2    = 3'd6,
    URGENTA   = 3'd7
  } stare_t;

  // Light code seen by one direction; the other direction's active phases show plain red.
  function automatic logic [1:0] cod_lumina(input stare_t s, input logic dir_ns);
    stare_t verde_s, galben_s, verde_op, galben_op;
    verde_s   = dir_ns ? NS_VERDE  : EV_VERDE;
    galben_s  = dir_ns ? NS_GALBEN : EV_GALBEN;
    verde_op  = dir_ns ? EV_VERDE  : NS_VERDE;
    galben_op = dir_ns ? EV_GALBEN : NS_GALBEN;
    if (s == verde_s)                        return VERDE;
    else if (s == galben_s)                  return GALBEN;
    else if (s == verde_op || s == galben_op) return ROSU;
    else                                     return ROSU_TOTAL;
  endfunction

  function automatic logic tranzit(input stare_t s, input logic dir_ns);
    return s == (dir_ns ? NS_GALBEN : EV_GALBEN);
  endfunction

endpackage

// File: rtl/contor_faza.sv
// Saturating phase counter with terminal-count compare against a per-state limit.
module contor_faza #(
  parameter int LATIME_CNT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  inc,
  input  logic [LATIME_CNT-1:0] limita,
  output logic [LATIME_CNT-1:0] cnt,
  output logic                  la_limita
);

  always_ff @(posedge clk) begin
    if (rst || clear)
      cnt <= '0;
    else if (inc && cnt != '1)
      cnt <= cnt + LATIME_CNT'(1);
  end

  assign la_limita = (cnt == limita);

endmodule

// File: rtl/secventiator_faze.sv
// Two-direction traffic phase sequencer with emergency all-red override.
// Optional pedestrian green cut enabled by defining PIETON_EN.
module secventiator_faze
  import faze_pkg::*;
#(
  parameter int T_VERDE      = 30,
  parameter int T_GALBEN     = 3,
  parameter int T_ROSU_TOTAL = 2,
  parameter int T_MIN_VERDE  = 10,
  parameter int LATIME_CNT   = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       tick_i,
  input  logic       urgenta_i,
  input  logic       cerere_pieton_i,
  output logic [1:0] w_ns_o,
  output logic       tranzit_ns_o,
  output logic [1:0] w_ev_o,
  output logic       tranzit_ev_o,
  output logic [2:0] faza_o
);

  localparam logic [LATIME_CNT-1:0] LIM_VERDE  = LATIME_CNT'(T_VERDE - 1);
  localparam logic [LATIME_CNT-1:0] LIM_GALBEN = LATIME_CNT'(T_GALBEN - 1);
  localparam logic [LATIME_CNT-1:0] LIM_ROSU   = LATIME_CNT'(T_ROSU_TOTAL - 1);

  stare_t                  stare, urmator;
  logic [LATIME_CNT-1:0]   limita;
  logic [LATIME_CNT-1:0]   contor;
  logic                    la_limita;
  logic                    pas;
  logic                    gata;
  logic                    taiere;

  assign pas = enable_i & tick_i;

  contor_faza #(.LATIME_CNT(LATIME_CNT)) u_contor (
    .clk       (clk_i),
    .rst       (rst_i),
    .clear     (urmator != stare),
    .inc       (pas && stare != URGENTA),
    .limita    (limita),
    .cnt       (contor),
    .la_limita (la_limita)
  );

`ifdef PIETON_EN
  localparam logic [LATIME_CNT-1:0] LIM_MIN = LATIME_CNT'(T_MIN_VERDE - 1);
  logic cerere;

  // A request arriving on the same edge as the red entry is kept for the next green.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      cerere <= 1'b0;
    else if ((urmator == ROSU_1 || urmator == ROSU_2) && urmator != stare)
      cerere <= cerere_pieton_i;
    else if (cerere_pieton_i)
      cerere <= 1'b1;
  end

  assign taiere = cerere && (stare == NS_VERDE || stare == EV_VERDE) && contor >= LIM_MIN;
`else
  logic unused_pieton;
  assign unused_pieton = cerere_pieton_i ^ (^contor);
  assign taiere = 1'b0;
`endif

  assign gata = pas & (la_limita | taiere);

  always_comb begin
    limita  = LIM_ROSU;
    urmator = stare;
    case (stare)
      NS_VERDE, EV_VERDE:   limita = LIM_VERDE;
      NS_GALBEN, EV_GALBEN: limita = LIM_GALBEN;
      default:              limita = LIM_ROSU;
    endcase
    if (urgenta_i) begin
      urmator = URGENTA;
    end else begin
      case (stare)
        URGENTA:   urmator = ROSU_INIT;
        ROSU_INIT: if (gata) urmator = NS_VERDE;
        NS_VERDE:  if (gata) urmator = NS_GALBEN;
        NS_GALBEN: if (gata) urmator = ROSU_1;
        ROSU_1:    if (gata) urmator = EV_VERDE;
        EV_VERDE:  if (gata) urmator = EV_GALBEN;
        EV_GALBEN: if (gata) urmator = ROSU_2;
        ROSU_2:    if (gata) urmator = NS_VERDE;
        default:   urmator = ROSU_INIT;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stare        <= ROSU_INIT;
      w_ns_o       <= ROSU_TOTAL;
      w_ev_o       <= ROSU_TOTAL;
      tranzit_ns_o <= 1'b0;
      tranzit_ev_o <= 1'b0;
      faza_o       <= ROSU_INIT;
    end else begin
      stare        <= urmator;
      w_ns_o       <= cod_lumina(urmator, 1'b1);
      w_ev_o       <= cod_lumina(urmator, 1'b0);
      tranzit_ns_o <= tranzit(urmator, 1'b1);
      tranzit_ev_o <= tranzit(urmator, 1'b0);
      faza_o       <= urmator;
    end
  end

endmodule

// File: tb/tb_secventiator_faze.sv
// Directed self-checking bench for secventiator_faze (default parameters);
// pedestrian expectation follows whether PIETON_EN is defined.
module tb_secventiator_faze;

  logic       clk = 1'b0;
  logic       rst, enable, tick, urgenta, pieton;
  logic [1:0] w_ns, w_ev;
  logic       tr_ns, tr_ev;
  logic [2:0] faza;

  int checks = 0;
  int errors = 0;
  int conflicte = 0;

  secventiator_faze dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .enable_i        (enable),
    .tick_i          (tick),
    .urgenta_i       (urgenta),
    .cerere_pieton_i (pieton),
    .w_ns_o          (w_ns),
    .tranzit_ns_o    (tr_ns),
    .w_ev_o          (w_ev),
    .tranzit_ev_o    (tr_ev),
    .faza_o          (faza)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && (w_ns == 2'b10 || w_ns == 2'b01) && (w_ev == 2'b10 || w_ev == 2'b01))
      conflicte++;

  task automatic verifica(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pas();
    @(posedge clk);
    #1;
  endtask

  // Counts edges while the selected light keeps the given code (bounded).
  task automatic masoara(input bit ev, input logic [1:0] cod, output int n);
    n = 0;
    while (((ev ? w_ev : w_ns) == cod) && n < 200) begin
      pas();
      n++;
    end
  endtask

  task automatic reseteaza();
    rst = 1'b1; enable = 1'b1; tick = 1'b1; urgenta = 1'b0; pieton = 1'b0;
    pas();
    pas();
    rst = 1'b0;
  endtask

  int n, k;

  initial begin
    // Reset and start-up
    reseteaza();
    verifica("rst_w_ns", w_ns, 2'b11);
    verifica("rst_w_ev", w_ev, 2'b11);
    verifica("rst_tranzit", {tr_ns, tr_ev}, 2'b00);
    verifica("rst_faza", faza, 3'd0);
    pas();
    verifica("init_tick1_w_ns", w_ns, 2'b11);
    pas();
    verifica("init_done_w_ns", w_ns, 2'b10);
    verifica("init_done_w_ev", w_ev, 2'b00);
    verifica("init_done_faza", faza, 3'd1);

    // Full cycle
    masoara(1'b0, 2'b10, n);
    verifica("ns_green_len", n, 30);
    verifica("ns_yellow_tranzit", tr_ns, 1'b1);
    masoara(1'b0, 2'b01, n);
    verifica("ns_yellow_len", n, 3);
    verifica("allred_w_ev", w_ev, 2'b11);
    masoara(1'b0, 2'b11, n);
    verifica("allred_len", n, 2);
    verifica("ev_green_w_ev", w_ev, 2'b10);
    verifica("ev_green_w_ns", w_ns, 2'b00);
    verifica("ev_green_faza", faza, 3'd4);

    // Freeze at NS_VERDE count 5
    reseteaza();
    pas(); pas();
    repeat (5) pas();
    enable = 1'b0;
    repeat (50) pas();
    verifica("freeze_faza", faza, 3'd1);
    verifica("freeze_w_ns", w_ns, 2'b10);
    enable = 1'b1;
    masoara(1'b0, 2'b10, n);
    verifica("freeze_resume_len", n, 25);

    // Emergency during EV_VERDE
    k = 0;
    while (w_ev != 2'b10 && k < 100) begin
      pas();
      k++;
    end
    verifica("reach_ev_green", w_ev, 2'b10);
    urgenta = 1'b1;
    pas();
    verifica("urg_w", {w_ns, w_ev}, 4'b1111);
    verifica("urg_faza", faza, 3'd7);
    repeat (3) pas();
    verifica("urg_hold_faza", faza, 3'd7);
    urgenta = 1'b0;
    pas();
    verifica("urg_exit_faza", faza, 3'd0);
    verifica("urg_exit_w", {w_ns, w_ev}, 4'b1111);
    pas();
    verifica("urg_init_tick1", faza, 3'd0);
    pas();
    verifica("urg_init_done", w_ns, 2'b10);

    // Simultaneous terminal tick, emergency and reset
    reseteaza();
    pas();
    rst = 1'b1; urgenta = 1'b1;
    pas();
    verifica("simul_rst_faza", faza, 3'd0);
    verifica("simul_rst_w", {w_ns, w_ev}, 4'b1111);
    rst = 1'b0; urgenta = 1'b0;
    pas();
    urgenta = 1'b1;
    pas();
    verifica("simul_urg_faza", faza, 3'd7);
    urgenta = 1'b0;

    // Pedestrian request at NS_VERDE count 3
    reseteaza();
    pas(); pas();
    repeat (3) pas();
    pieton = 1'b1;
    pas();
    pieton = 1'b0;
    masoara(1'b0, 2'b10, n);
`ifdef PIETON_EN
    verifica("pieton_green_len", n + 4, 10);
`else
    verifica("pieton_green_len", n + 4, 30);
`endif
    verifica("pieton_then_yellow", w_ns, 2'b01);

    verifica("never_both_go", conflicte, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
